// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave: loader side; master: host/memory side.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads word_count little-endian 32-bit words from a byte stream into IMEM.
// Ports: clk, rst_n, start/word_count/abort, bus (stream + mem), busy/done/err/loaded_words.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  localparam int CW = $clog2(MEM_SIZE) + 1,
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] word_count,
  input  logic          abort,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] loaded_words
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] MAXC = CW'(MEM_SIZE);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_loaded;
  logic [IW-1:0]         r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_err;

  logic w_in_ready;
  logic w_we;
  logic w_busy;
  logic w_done;
  logic w_hs;
  logic w_cnt_ok;
  logic w_last;

  assign w_cnt_ok = (word_count != '0) && (word_count <= MAXC);
  assign w_hs     = bus.in_valid && w_in_ready;
  // Widen word_idx so the final index MEM_SIZE-1 compares without overflow.
  assign w_last   = (CW'(r_word_idx) + CW'(1)) == r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && w_cnt_ok) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (abort)
          w_next = S_IDLE;
        else if (bus.in_valid && r_byte_idx == 2'd3)
          w_next = S_WRITE;
      end
      S_WRITE: begin
        w_busy = 1'b1;
        // Abort wins: the write strobe is suppressed this cycle.
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_we   = 1'b1;
          w_next = w_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_loaded   <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cnt_ok) begin
              r_count    <= word_count;
              r_loaded   <= '0;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_err      <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_err      <= 1'b1;
            r_byte_idx <= '0;
          end else if (w_hs) begin
            r_word[8*r_byte_idx +: 8] <= bus.in_data;
            r_byte_idx                <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          if (abort) begin
            r_err      <= 1'b1;
            r_byte_idx <= '0;
          end else begin
            r_loaded <= r_loaded + CW'(1);
            // Hold the index on the final word so it never passes MEM_SIZE-1.
            if (!w_last) r_word_idx <= r_word_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = ADDR_WIDTH'({r_word_idx, 2'b00});
  assign bus.mem_wdata = r_word;
  assign busy          = w_busy;
  assign done          = w_done;
  assign err           = r_err;
  assign loaded_words  = r_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Expected writes are queued as bytes are driven and popped on mem_we.
module tb_imem_loader;
  localparam int MS = 512;
  localparam int CW = $clog2(MS) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] wc    = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] lw;

  imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

  imem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE(MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .word_count  (wc),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .loaded_words(lw)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_we    = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      n_we++;
      chk("rdy_in_wr", 32'(bus.in_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("spur_we", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("we_addr", bus.mem_addr, mon_e[63:32]);
        chk("we_data", bus.mem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("rdy_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic do_start(input int cnt);
    wc    = CW'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int cnt, input logic [31:0] w0,
                      input int gmax);
    logic [31:0] w;
    do_start(cnt);
    chk("ld_busy", 32'(busy), 32'd1);
    chk("ld_err", 32'(err), 32'd0);
    chk("ld_lw", 32'(lw), 32'd0);
    for (int i = 0; i < cnt; i++) begin
      w = (i == 0) ? w0 : $urandom;
      sb.push_back({32'(i * 4), w});
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(gmax, 0)) tick();
        send_byte(w[8*b +: 8]);
      end
      chk("we_lat", 32'(bus.mem_we), 32'd1);
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_off", 32'(busy), 32'd0);
    chk("lw_cnt", 32'(lw), 32'(cnt));
    tick();
    chk("done_1cyc", 32'(done), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_lw"}, 32'(lw), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int we0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 rst_n = 1'b0;
    #12;
    chk_zero("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // single word, back-to-back bytes
    load(1, 32'h0000_0013, 0);

    // three words with random stalls
    load(3, 32'h0403_0201, 3);

    // illegal counts: err set, no load, loaded_words kept
    do_start(0);
    chk("bad0_err", 32'(err), 32'd1);
    chk("bad0_busy", 32'(busy), 32'd0);
    chk("bad0_lw", 32'(lw), 32'd3);
    tick();
    do_start(MS + 1);
    chk("badN_err", 32'(err), 32'd1);
    chk("badN_busy", 32'(busy), 32'd0);
    chk("badN_lw", 32'(lw), 32'd3);
    tick();
    chk("badN_idle", 32'(bus.in_ready), 32'd0);

    // abort on the 4th byte of word 2 of 4
    do_start(4);
    chk("ab_err_clr", 32'(err), 32'd0);
    sb.push_back({32'd0, 32'hCAFE_F00D});
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hFE);
    send_byte(8'hCA);
    chk("ab_we_w1", 32'(bus.mem_we), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    abort        = 1'b1;
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    chk("ab_err", 32'(err), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_we", 32'(bus.mem_we), 32'd0);
    chk("ab_rdy", 32'(bus.in_ready), 32'd0);
    chk("ab_lw", 32'(lw), 32'd1);
    repeat (3) tick();
    chk("ab_lw_hold", 32'(lw), 32'd1);
    chk("ab_sb", 32'(sb.size()), 32'd0);

    // reset in the middle of a load
    do_start(2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(1, 32'hDEAD_BEEF, 0);

    // fill the whole memory
    we0 = n_we;
    load(MS, $urandom, 0);
    chk("full_we_cnt", 32'(n_we - we0), 32'(MS));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction word width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width of mem_addr.
REQ-003 SHALL have parameter MEM_SIZE, default 512: number of instruction-memory words.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: load request, sampled only in IDLE.
REQ-007 SHALL have port word_count, input, $clog2(MEM_SIZE)+1: words to load, sampled with start.
REQ-008 SHALL have port abort, input, 1: cancel an in-progress load.
REQ-009 SHALL have port in_valid, input, 1: byte-stream valid.
REQ-010 SHALL have port in_data, input, 8: byte-stream data, little-endian within each word.
REQ-011 SHALL have port in_ready, output, 1: byte-stream ready.
REQ-012 SHALL have port mem_we, output, 1: instruction-memory write strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH: word-aligned byte address; bits [1:0] always 0.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH: word to write.
REQ-015 SHALL have port busy, output, 1: load in progress; holds the CPU in reset.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-017 SHALL have port err, output, 1: sticky error flag.
REQ-018 SHALL have port loaded_words, output, $clog2(MEM_SIZE)+1: words committed by the last load.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-020 SHALL, in IDLE with start=1 and 1<=word_count<=MEM_SIZE, latch word_count, clear byte_idx, word_idx, loaded_words and err, and go to LOAD.
REQ-021 SHALL, in IDLE with start=1 and word_count==0 or word_count>MEM_SIZE, set err, leave loaded_words unchanged, and stay in IDLE.
REQ-022 SHALL ignore start in every state other than IDLE.
REQ-023 SHALL drive in_ready=1 only in LOAD.
REQ-024 SHALL accept a byte only on a cycle where in_valid&&in_ready, placing it in lane byte_idx (bits 8*byte_idx+7:8*byte_idx) and incrementing byte_idx mod 4.
REQ-025 SHALL, on accepting byte 3, go to WRITE on the next edge.
REQ-026 SHALL, in WRITE, drive mem_we=1 for exactly one cycle with mem_wdata=assembled word and mem_addr=word_idx*4.
REQ-027 SHALL make the write latency exactly 1 cycle after the 4th byte handshake.
REQ-028 SHALL, at the end of WRITE, increment word_idx and loaded_words, then go to DONE if word_idx+1==latched count, else to LOAD.
REQ-029 SHALL pulse done=1 in DONE for one cycle, then return to IDLE.
REQ-030 SHALL drive busy=1 in LOAD and WRITE, and 0 otherwise.
REQ-031 SHALL drive mem_we=0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-032 SHALL, on abort=1 in LOAD or WRITE, go to IDLE next edge, set err, suppress the pending write (no mem_we that cycle), and discard partial bytes.
REQ-033 SHALL give abort priority over a same-cycle byte handshake; that byte is not counted.
REQ-034 SHALL never let word_idx exceed MEM_SIZE-1; mem_addr SHALL not wrap.
REQ-035 SHALL ignore in_data while in_valid=0 or in_ready=0.
REQ-036 SHALL tolerate stalls: any number of idle cycles between bytes, with no timeout.

Reset
REQ-037 SHALL, while rst_n=0, force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, loaded_words=0, byte_idx=0, word_idx=0, asynchronously.
REQ-038 SHALL, on reset assertion mid-load, abandon the load with no further mem_we; after reset release the block sits in IDLE awaiting start.

Verification
REQ-039 SHALL cover a single-word load: start, word_count=1; bytes 13,00,00,00 back-to-back -> one mem_we with addr 0x0, wdata 0x00000013; done pulse 1 cycle later; loaded_words=1.
REQ-040 SHALL cover a multi-word load with stalls: word_count=3, random in_valid gaps -> writes at 0x0, 0x4, 0x8 in order, correct little-endian words, in_ready=0 during each WRITE cycle.
REQ-041 SHALL cover illegal counts: start with word_count=0, then with MEM_SIZE+1 -> err=1, busy stays 0, no mem_we.
REQ-042 SHALL cover abort on a 4th-byte cycle: abort with the byte handshake of word 2 of 4 -> no write for word 2, err=1, IDLE, loaded_words=1.
REQ-043 SHALL cover reset mid-load: rst_n low during LOAD after 2 bytes -> all outputs 0 immediately; a fresh word_count=1 load then writes 0x0 correctly.
REQ-044 SHALL cover a full-memory load: word_count=MEM_SIZE -> last write at addr (MEM_SIZE-1)*4, done pulse, loaded_words=MEM_SIZE.
